// File: rtl/pool_pkg.sv
// Shared definitions for the 14x14 -> 7x7 max-pool collection path.
//
// Contents:
//   PIX_W        pixel width in bits
//   POOL_IN_DIM  side of the incoming feature map (14)
//   POOL_OUT_DIM side of the pooled map (7)
//   POOL_OUT_N   pooled outputs per frame (49)
//   IDX_W        width of the pool window index
//   pool_state_e collector FSM states
package pool_pkg;

    localparam int unsigned PIX_W        = 8;
    localparam int unsigned POOL_IN_DIM  = 14;
    localparam int unsigned POOL_OUT_DIM = POOL_IN_DIM / 2;
    localparam int unsigned POOL_OUT_N   = POOL_OUT_DIM * POOL_OUT_DIM;
    localparam int unsigned IDX_W        = 6;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } pool_state_e;

endpackage

// File: rtl/pool_collect7x7.sv
// Sequencer and result buffer behind the 14x14 2x2 max-pool stage.
//
// Steps the pool window index 0..48 while the upstream map is held, captures
// each pooled pixel into a 7x7 buffer and offers the finished map downstream.
//
// Optional feature macro: POOL_RELU_EN
//   defined   - pool_out is treated as signed; negative values are stored as 0
//   undefined - pool_out is stored raw
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream 14x14 map valid and held stable
//   in_ready   one-cycle pulse: frame consumed, upstream may change its data
//   pool_idx   window index to the pool stage (0 outside SCAN)
//   pool_out   combinational pooled value for the current pool_idx
//   out_valid  fmap holds a complete 7x7 frame
//   out_ready  downstream accepts fmap
//   fmap       pooled map, slot k = fmap[k*PIX_W +: PIX_W], k = row*7+col
module pool_collect7x7 #(
    parameter int unsigned PIX_W = pool_pkg::PIX_W,
    parameter int unsigned OUT_N = pool_pkg::POOL_OUT_N
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [pool_pkg::IDX_W-1:0]   pool_idx,
    input  logic [PIX_W-1:0]             pool_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PIX_W*OUT_N-1:0]       fmap
);

    import pool_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_N - 1);

    pool_state_e            state_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [PIX_W*OUT_N-1:0] fmap_q;
    logic [PIX_W-1:0]       pix_val;

    // Value written into the current slot.
    always_comb begin
`ifdef POOL_RELU_EN
        pix_val = pool_out[PIX_W-1] ? '0 : pool_out;
`else
        pix_val = pool_out;
`endif
    end

    // idx_q is kept at 0 outside SCAN so it can drive pool_idx directly.
    // in_ready_q is set one cycle early so it is high exactly while idx_q == LAST_IDX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            fmap_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                    end
                end
                SCAN: begin
                    for (int k = 0; k < int'(OUT_N); k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            fmap_q[k*PIX_W +: PIX_W] <= pix_val;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q     <= DONE;
                        idx_q       <= '0;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q      <= idx_q + 1'b1;
                        in_ready_q <= (idx_q == LAST_IDX - 1'b1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        // Back-to-back: a waiting frame starts without an IDLE cycle.
                        state_q     <= in_valid ? SCAN : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign pool_idx  = idx_q;
    assign fmap      = fmap_q;

endmodule

// File: tb/tb_pool_collect7x7.sv
// Self-checking bench for pool_collect7x7.
// A behavioural 14x14 image drives a behavioural 2x2 max-pool stage; the
// expected 7x7 map is derived from the image by a separate reference routine.
module tb_pool_collect7x7;

    localparam int PIX_W   = 8;
    localparam int OUT_N   = 49;
    localparam int IN_DIM  = 14;
    localparam int OUT_DIM = 7;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [5:0]             pool_idx;
    logic [PIX_W-1:0]       pool_out;
    logic                   out_valid;
    logic                   out_ready;
    logic [PIX_W*OUT_N-1:0] fmap;

    int checks       = 0;
    int errors       = 0;
    int ready_pulses = 0;

    logic [7:0]             img     [IN_DIM*IN_DIM];
    logic [7:0]             exp_map [OUT_N];

    always #5 clk = ~clk;

    pool_collect7x7 #(
        .PIX_W (PIX_W),
        .OUT_N (OUT_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pool_idx  (pool_idx),
        .pool_out  (pool_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fmap      (fmap)
    );

    function automatic logic [7:0] pmax(input logic [7:0] a, input logic [7:0] b);
`ifdef POOL_RELU_EN
        return ($signed(a) > $signed(b)) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    // Combinational pool stage model.
    always_comb begin
        int b;
        b = (int'(pool_idx) / OUT_DIM) * 2 * IN_DIM + (int'(pool_idx) % OUT_DIM) * 2;
        if (pool_idx < 6'd49) begin
            pool_out = pmax(pmax(img[b], img[b+1]), pmax(img[b+IN_DIM], img[b+IN_DIM+1]));
        end else begin
            pool_out = '0;
        end
    end

    // Expected map: max over each 2x2 window, then optional clamp.
    task automatic compute_expected();
        for (int k = 0; k < OUT_N; k++) begin
            int r0 = 2 * (k / OUT_DIM);
            int c0 = 2 * (k % OUT_DIM);
            logic [7:0] m = img[r0*IN_DIM + c0];
            for (int dr = 0; dr < 2; dr++) begin
                for (int dc = 0; dc < 2; dc++) begin
                    m = pmax(m, img[(r0+dr)*IN_DIM + c0 + dc]);
                end
            end
`ifdef POOL_RELU_EN
            if (m[7]) m = 8'h00;
`endif
            exp_map[k] = m;
        end
    endtask

    function automatic logic [PIX_W*OUT_N-1:0] expected_vec();
        logic [PIX_W*OUT_N-1:0] v;
        for (int k = 0; k < OUT_N; k++) v[k*PIX_W +: PIX_W] = exp_map[k];
        return v;
    endfunction

    task automatic load_random();
        for (int i = 0; i < IN_DIM*IN_DIM; i++) img[i] = 8'($urandom);
        compute_expected();
    endtask

    task automatic load_const(input logic [7:0] v);
        for (int i = 0; i < IN_DIM*IN_DIM; i++) img[i] = v;
        compute_expected();
    endtask

    task automatic load_ramp();
        for (int i = 0; i < IN_DIM*IN_DIM; i++) img[i] = 8'(i);
        compute_expected();
    endtask

    // Range and in_ready monitor, active every cycle outside reset.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (pool_idx > 6'd48) begin
                errors++;
                $display("FAIL pool_idx_range: got %0d, limit 48", pool_idx);
            end
            if (in_ready === 1'b1) begin
                ready_pulses++;
                checks++;
                if (pool_idx !== 6'd48) begin
                    errors++;
                    $display("FAIL in_ready_idx: pool_idx %0d during in_ready, want 48", pool_idx);
                end
            end
        end
    end

    // Starts a frame from IDLE; returns edges from the accepting edge to out_valid
    // (-1 on timeout) and the number of in_ready pulses seen.
    task automatic drive_frame(output int lat, output int pulses);
        int p0;
        p0       = ready_pulses;
        lat      = -1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 200 && lat < 0; n++) begin
            if (in_ready) in_valid = 1'b0;
            @(posedge clk); #1;
            if (out_valid) lat = n;
        end
        in_valid = 1'b0;
        pulses   = ready_pulses - p0;
    endtask

    task automatic accept_frame();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_clears_valid: got %b, want 0", out_valid);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        load_const(8'h00);
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, want 0", in_ready); end
        if (pool_idx !== 6'd0) begin errors++; $display("FAIL reset_pool_idx: got %0d, want 0", pool_idx); end
        if (fmap !== '0) begin errors++; $display("FAIL reset_fmap: got %h, want 0", fmap); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        int lat, pulses;
        load_ramp();
        drive_frame(lat, pulses);
        checks += 4;
        if (lat != 49) begin errors++; $display("FAIL ramp_latency: got %0d edges, want 49", lat); end
        if (pulses != 1) begin errors++; $display("FAIL ramp_in_ready_pulses: got %0d, want 1", pulses); end
        if (fmap !== expected_vec()) begin
            errors++;
            $display("FAIL ramp_fmap: got %h, want %h", fmap, expected_vec());
        end
        if (pool_idx !== 6'd0) begin errors++; $display("FAIL ramp_done_idx: got %0d, want 0", pool_idx); end
`ifndef POOL_RELU_EN
        checks += 2;
        if (fmap[7:0] !== 8'd15) begin errors++; $display("FAIL ramp_slot0: got %0d, want 15", fmap[7:0]); end
        if (fmap[48*8 +: 8] !== 8'd195) begin
            errors++;
            $display("FAIL ramp_slot48: got %0d, want 195", fmap[48*8 +: 8]);
        end
`endif
        accept_frame();
    endtask

    task automatic test_handshake();
        int lat, pulses;
        logic [PIX_W*OUT_N-1:0] ev;
        load_random();
        ev = expected_vec();
        drive_frame(lat, pulses);
        checks += 2;
        if (lat != 49) begin errors++; $display("FAIL hs_latency: got %0d edges, want 49", lat); end
        if (pulses != 1) begin errors++; $display("FAIL hs_in_ready_pulses: got %0d, want 1", pulses); end
        for (int i = 0; i < 20; i++) begin
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL hs_hold_valid: cycle %0d got %b, want 1", i, out_valid); end
            if (pool_idx !== 6'd0) begin errors++; $display("FAIL hs_hold_idx: cycle %0d got %0d, want 0", i, pool_idx); end
            if (fmap !== ev) begin errors++; $display("FAIL hs_hold_fmap: cycle %0d got %h, want %h", i, fmap, ev); end
            @(posedge clk); #1;
        end
        accept_frame();
        // out_ready while idle must not raise anything.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks += 2;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_ready_valid: got %b, want 0", out_valid); end
            if (pool_idx !== 6'd0) begin errors++; $display("FAIL idle_ready_idx: got %0d, want 0", pool_idx); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [PIX_W*OUT_N-1:0] ev1, ev2;
        logic [PIX_W*OUT_N-1:0] all7f;
        int nready, nvalid, t1, t2;
        bit switch_pending;
        all7f = {OUT_N{8'h7F}};
        load_ramp();
        ev1 = expected_vec();
        ev2 = '0;
        nready = 0; nvalid = 0; t1 = -1; t2 = -1; switch_pending = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int n = 1; n <= 300 && nvalid < 2; n++) begin
            @(posedge clk); #1;
            if (switch_pending) begin
                // Upstream moves to the next frame once the last window was captured.
                load_const(8'h7F);
                ev2 = expected_vec();
                switch_pending = 0;
            end
            if (in_ready) begin
                nready++;
                if (nready == 1) switch_pending = 1;
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                nvalid++;
                checks++;
                if (nvalid == 1) begin
                    t1 = n;
                    if (fmap !== ev1) begin errors++; $display("FAIL b2b_fmap1: got %h, want %h", fmap, ev1); end
                end else begin
                    t2 = n;
                    if (fmap !== ev2) begin errors++; $display("FAIL b2b_fmap2: got %h, want %h", fmap, ev2); end
                end
            end
        end
        checks += 3;
        if (t1 != 50) begin errors++; $display("FAIL b2b_first_valid: got cycle %0d, want 50", t1); end
        if (t2 - t1 != 50 || t2 < 0) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles, want 50", t2 - t1);
        end
        if (fmap !== all7f) begin errors++; $display("FAIL b2b_all7f: got %h, want %h", fmap, all7f); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b, want 0", out_valid); end
    endtask

    task automatic test_reset_mid_scan();
        int lat, pulses;
        bit found;
        load_random();
        found    = 0;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !found; n++) begin
            @(posedge clk); #1;
            if (pool_idx == 6'd20) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_reach_idx20: got %0d, want 20", pool_idx); end
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checks += 4;
        if (pool_idx !== 6'd0) begin errors++; $display("FAIL mid_rst_idx: got %0d, want 0", pool_idx); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, want 0", out_valid); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b, want 0", in_ready); end
        if (fmap !== '0) begin errors++; $display("FAIL mid_rst_fmap: got %h, want 0", fmap); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pool_idx !== 6'd0) begin errors++; $display("FAIL mid_post_idle: got %0d, want 0", pool_idx); end
        load_random();
        drive_frame(lat, pulses);
        checks += 3;
        if (lat != 49) begin errors++; $display("FAIL mid_fresh_latency: got %0d, want 49", lat); end
        if (pulses != 1) begin errors++; $display("FAIL mid_fresh_pulses: got %0d, want 1", pulses); end
        if (fmap !== expected_vec()) begin
            errors++;
            $display("FAIL mid_fresh_fmap: got %h, want %h", fmap, expected_vec());
        end
        accept_frame();
    endtask

    task automatic test_relu();
        int lat, pulses, w, pos, other;
        logic [7:0] got_w, got_o;
        load_const(8'h80);
        w     = int'($urandom_range(0, OUT_N - 1));
        pos   = int'($urandom_range(0, 3));
        other = (w + 1) % OUT_N;
        img[(2*(w/OUT_DIM) + pos/2)*IN_DIM + 2*(w%OUT_DIM) + pos%2] = 8'h05;
        compute_expected();
        drive_frame(lat, pulses);
        got_w = fmap[w*8 +: 8];
        got_o = fmap[other*8 +: 8];
        checks += 3;
        if (fmap !== expected_vec()) begin
            errors++;
            $display("FAIL relu_fmap: got %h, want %h", fmap, expected_vec());
        end
`ifdef POOL_RELU_EN
        if (got_w !== 8'h05) begin errors++; $display("FAIL relu_slot: slot %0d got %h, want 05", w, got_w); end
        if (got_o !== 8'h00) begin errors++; $display("FAIL relu_other: slot %0d got %h, want 00", other, got_o); end
`else
        if (got_w !== 8'h80) begin errors++; $display("FAIL raw_slot: slot %0d got %h, want 80", w, got_w); end
        if (got_o !== 8'h80) begin errors++; $display("FAIL raw_other: slot %0d got %h, want 80", other, got_o); end
`endif
        accept_frame();
    endtask

    task automatic test_random_frames();
        int lat, pulses;
        for (int f = 0; f < 3; f++) begin
            load_random();
            drive_frame(lat, pulses);
            checks += 3;
            if (lat != 49) begin errors++; $display("FAIL rand_latency: frame %0d got %0d, want 49", f, lat); end
            if (pulses != 1) begin errors++; $display("FAIL rand_pulses: frame %0d got %0d, want 1", f, pulses); end
            if (fmap !== expected_vec()) begin
                errors++;
                $display("FAIL rand_fmap: frame %0d got %h, want %h", f, fmap, expected_vec());
            end
            accept_frame();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp();
        test_handshake();
        test_back_to_back();
        test_reset_mid_scan();
        test_relu();
        test_random_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
